// File: rtl/acc_nbit_burst.sv
// Burst accumulator: sums COUNT operands through a ripple-carry adder built from
// 1-bit full adders, tracks a sticky carry-out flag and hands the total over valid/ready.

module FA_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module FA_nbit_Using_1bit_FA #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);
  logic [WIDTH:0] w_c;

  assign w_c[0] = Cin;
  assign Cout   = w_c[WIDTH];

  // one full-adder slice per bit, carry rippling upward
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    FA_1bit u_fa (
      .a    (in1[g]),
      .b    (in2[g]),
      .cin  (w_c[g]),
      .s    (Sum[g]),
      .cout (w_c[g+1])
    );
  end
endmodule

module acc_nbit_burst #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned COUNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] acc_sum,
  output logic             acc_ovf,
  output logic             busy
);
  localparam int unsigned CW = $clog2(COUNT + 1);
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);

  localparam logic [0:0] S_ACCUM = 1'b0;
  localparam logic [0:0] S_DONE  = 1'b1;

  logic [0:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_ovf;

  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  FA_nbit_Using_1bit_FA #(.WIDTH(WIDTH)) u_add (
    .in1  (r_sum),
    .in2  (in_data),
    .Cin  (1'b0),
    .Sum  (w_sum),
    .Cout (w_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_ACCUM;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
    end else if (clear) begin
      // abort beats any same-cycle accept or delivery
      r_state <= S_ACCUM;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_ACCUM: begin
          if (in_valid) begin
            r_sum <= w_sum;
            r_ovf <= r_ovf | w_cout;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_ACCUM;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_ovf   <= 1'b0;
          end
        end
        default: r_state <= S_ACCUM;
      endcase
    end
  end

  // handshake outputs depend on state only
  assign in_ready  = (r_state == S_ACCUM);
  assign out_valid = (r_state == S_DONE);
  assign acc_sum   = r_sum;
  assign acc_ovf   = r_ovf;
  assign busy      = (r_cnt != '0) || (r_state == S_DONE);

endmodule

// File: tb/tb_acc_nbit_burst.sv
// Directed and random bursts against a queue-based model of the accumulator.

module tb_acc_nbit_burst;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned COUNT = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] acc_sum;
  logic             acc_ovf;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int q[$];

  acc_nbit_burst #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_sum   (acc_sum),
    .acc_ovf   (acc_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic int exp_sum();
    int t = 0;
    foreach (q[i]) t = (t + q[i]) % (1 << WIDTH);
    return t;
  endfunction

  function automatic int exp_ovf();
    int t = 0;
    int o = 0;
    foreach (q[i]) begin
      if (t + q[i] >= (1 << WIDTH)) o = 1;
      t = (t + q[i]) % (1 << WIDTH);
    end
    return o;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    bit done;
    done = (q.size() == COUNT);
    chk({tag, ".sum"},       int'(acc_sum),   exp_sum());
    chk({tag, ".ovf"},       int'(acc_ovf),   exp_ovf());
    chk({tag, ".in_ready"},  int'(in_ready),  int'(!done));
    chk({tag, ".out_valid"}, int'(out_valid), int'(done));
    chk({tag, ".busy"},      int'(busy),      int'(q.size() != 0));
  endtask

  // one clock: drive at negedge, update model at posedge, check just after
  task automatic step(input string tag, input bit v, input int d,
                      input bit ordy, input bit clr);
    bit done;
    @(negedge clk);
    in_valid  = v;
    in_data   = WIDTH'(d);
    out_ready = ordy;
    clear     = clr;
    done = (q.size() == COUNT);
    @(posedge clk);
    if (clr) q.delete();
    else if (!done && v) q.push_back(d);
    else if (done && ordy) q.delete();
    #1;
    chk_all(tag);
  endtask

  task automatic burst(input string tag, input int a, input int b,
                       input int c, input int e);
    step(tag, 1, a, 1, 0);
    step(tag, 1, b, 1, 0);
    step(tag, 1, c, 1, 0);
    step(tag, 1, e, 1, 0);
  endtask

  initial begin
    #2;
    chk_all("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    step("idle", 0, 0, 1, 0);

    // basic burst, result delivered next cycle
    burst("basic", 10, 20, 30, 40);
    chk("basic.final", int'(acc_sum), 100);
    step("basic_out", 0, 0, 1, 0);

    // wrap and sticky overflow, then clean next burst
    burst("wrap", 200, 100, 1, 2);
    chk("wrap.final", int'(acc_sum), 47);
    chk("wrap.ovf1", int'(acc_ovf), 1);
    step("wrap_out", 0, 0, 1, 0);
    burst("wrap2", 1, 1, 1, 1);
    chk("wrap2.ovf0", int'(acc_ovf), 0);
    step("wrap2_out", 0, 0, 1, 0);

    // backpressure in DONE with garbage input present
    burst("bp", 5, 5, 5, 5);
    for (int i = 0; i < 5; i++) step("bp_hold", 1, 99, 0, 0);
    chk("bp.sum", int'(acc_sum), 20);
    step("bp_out", 0, 0, 1, 0);

    // bubbles of 0..3 cycles
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < i; g++) step("bubble_gap", 0, 0, 1, 0);
      step("bubble", 1, 3, 1, 0);
    end
    chk("bubble.sum", int'(acc_sum), 12);
    step("bubble_out", 0, 0, 1, 0);

    // clear wins over accept, then clear in DONE
    step("clr", 1, 7, 1, 0);
    step("clr", 1, 8, 1, 0);
    step("clr_hit", 1, 50, 1, 1);
    chk("clr.busy", int'(busy), 0);
    burst("clr_after", 1, 2, 3, 4);
    chk("clr_after.sum", int'(acc_sum), 10);
    step("clr_done", 0, 0, 1, 1);

    // async reset between edges mid-burst
    step("ar", 1, 9, 0, 0);
    step("ar", 1, 9, 0, 0);
    step("ar", 1, 9, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk_all("ar_now");
    @(negedge clk);
    rst_n = 1'b1;
    burst("ar_after", 9, 9, 9, 9);
    chk("ar_after.sum", int'(acc_sum), 36);
    step("ar_out", 0, 0, 1, 0);

    // random traffic
    for (int i = 0; i < 400; i++)
      step("rand", $urandom_range(0, 3) != 0, $urandom_range(0, 255),
           $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
